register_bank: RTL and testbench

REGISTER_BANK -- requirements
Module: register_bank

---
 rtl/register_bank_pkg.sv | 12 +
 rtl/register_cell.sv | 52 +++++
 rtl/register_bank.sv | 60 ++++++
 tb/tb_register_bank.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/register_bank_pkg.sv
// Shared definitions for register_bank: the 2-bit operation encoding applied to the addressed
// register.
package register_bank_pkg;

  typedef enum logic [1:0] {
    MODE_LOAD = 2'b00,
    MODE_INC  = 2'b01,
    MODE_DEC  = 2'b10,
    MODE_CLR  = 2'b11
  } mode_e;

endpackage

// File: rtl/register_cell.sv
// One WIDTH-bit register that supports load/inc/dec/clear.
// wrap_o is a registered pulse that is high for the cycle after an INC or DEC wraps around.
module register_cell
  import register_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  mode_e            op_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] val_d, val_q;
  logic             wrap_d, wrap_q;

  always_comb begin
    val_d  = val_q;
    wrap_d = 1'b0;
    if (en_i) begin
      unique case (op_i)
        MODE_LOAD: val_d = d_i;
        MODE_INC: begin
          val_d  = val_q + WIDTH'(1);
          wrap_d = &val_q;
        end
        MODE_DEC: begin
          val_d  = val_q - WIDTH'(1);
          wrap_d = ~|val_q;
        end
        MODE_CLR: val_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      val_q  <= val_d;
      wrap_q <= wrap_d;
    end
  end

  assign q_o    = val_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/register_bank.sv
// Bank of DEPTH counters/registers with two combinational read ports toward the ALU.
// Define REGISTER_BANK_BYPASS_EN to forward LOAD data to a read port whose address matches waddr
// in the same cycle.
module register_bank
  import register_bank_pkg::*;
#(
  parameter  int unsigned WIDTH  = 8,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_n,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  w_bus,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic              zero_a,
  output logic              ovf
);

  mode_e            op;
  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] wrap;

  assign op = mode_e'(mode);

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    register_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (!load_n && (waddr == ADDR_W'(i))),
      .op_i   (op),
      .d_i    (w_bus),
      .q_o    (regs[i]),
      .wrap_o (wrap[i])
    );
  end

  // Each cell's wrap bit is already registered, so the OR is still a clean one-cycle pulse.
  assign ovf = |wrap;

`ifdef REGISTER_BANK_BYPASS_EN
  logic load_fwd;
  assign load_fwd = !load_n && (op == MODE_LOAD);
  assign alu_a    = (load_fwd && (raddr_a == waddr)) ? w_bus : regs[raddr_a];
  assign alu_b    = (load_fwd && (raddr_b == waddr)) ? w_bus : regs[raddr_b];
`else
  assign alu_a = regs[raddr_a];
  assign alu_b = regs[raddr_b];
`endif

  assign zero_a = (alu_a == '0);

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed scenarios plus randomized operations
// checked against an array-based reference model.
module tb_register_bank;

  localparam int W = 8;
  localparam int D = 4;
  localparam int AW = 2;
  localparam int MASK = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_n = 1'b1;
  logic [AW-1:0] waddr = '0;
  logic [1:0]    mode = 2'b00;
  logic [W-1:0]  w_bus = '0;
  logic [AW-1:0] raddr_a = '0;
  logic [AW-1:0] raddr_b = '0;
  logic [W-1:0]  alu_a, alu_b;
  logic          zero_a, ovf;

  int mdl [D];
  int n_checks = 0;
  int n_fail = 0;

  register_bank #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_n  (load_n),
    .waddr   (waddr),
    .mode    (mode),
    .w_bus   (w_bus),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .zero_a  (zero_a),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected read-port value given the currently driven inputs.
  function automatic int exp_read(input int ra);
`ifdef REGISTER_BANK_BYPASS_EN
    if (!load_n && mode == 2'b00 && ra == int'(waddr)) return int'(w_bus);
`endif
    return mdl[ra];
  endfunction

  task automatic check_reads(input string tag);
    check({tag, " alu_a"}, int'(alu_a), exp_read(int'(raddr_a)));
    check({tag, " alu_b"}, int'(alu_b), exp_read(int'(raddr_b)));
    check({tag, " zero_a"}, int'(zero_a), int'(exp_read(int'(raddr_a)) == 0));
  endtask

  // Sweep every register through both ports within one low clock phase.
  task automatic check_all_regs(input string tag);
    @(negedge clk);
    load_n = 1'b1;
    for (int i = 0; i < D; i++) begin
      raddr_a = AW'(i);
      raddr_b = AW'(D - 1 - i);
      #1;
      check({tag, " reg_a"}, int'(alu_a), mdl[i]);
      check({tag, " reg_b"}, int'(alu_b), mdl[D - 1 - i]);
    end
  endtask

  // Drive one cycle, check reads before and after the edge and the ovf pulse.
  task automatic do_op(input bit ln, input int m, input int wa, input int wb,
                       input int ra, input int rb, input string tag);
    int old_v;
    int new_v;
    int e_ovf;
    @(negedge clk);
    load_n  = ln;
    mode    = 2'(m);
    waddr   = AW'(wa);
    w_bus   = W'(wb);
    raddr_a = AW'(ra);
    raddr_b = AW'(rb);
    #1;
    check_reads({tag, " pre"});
    @(posedge clk);
    #1;
    e_ovf = 0;
    if (!ln) begin
      old_v = mdl[wa];
      case (m)
        0: new_v = wb & MASK;
        1: begin new_v = (old_v + 1) & MASK; e_ovf = int'(old_v == MASK); end
        2: begin new_v = (old_v - 1) & MASK; e_ovf = int'(old_v == 0); end
        default: new_v = 0;
      endcase
      mdl[wa] = new_v;
    end
    check({tag, " ovf"}, int'(ovf), e_ovf);
    check_reads({tag, " post"});
  endtask

  initial begin
    for (int i = 0; i < D; i++) mdl[i] = 0;
    #3;
    check("reset ovf", int'(ovf), 0);
    check("reset zero_a", int'(zero_a), 1);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    check_all_regs("after reset");

    // Seed nonzero values so LOAD to reg2 proves the neighbours hold.
    do_op(0, 0, 0, 8'h11, 0, 0, "seed0");
    do_op(0, 0, 1, 8'h22, 1, 1, "seed1");
    do_op(0, 0, 3, 8'h33, 3, 3, "seed3");
    do_op(0, 0, 2, 8'hA5, 2, 0, "load reg2");
    do_op(1, 0, 0, 8'h00, 2, 2, "read reg2");
    check("reg2 value", int'(alu_a), 8'hA5);
    check_all_regs("after load");

    // INC wrap.
    do_op(0, 0, 1, 8'hFF, 1, 0, "set reg1 ff");
    do_op(0, 1, 1, 8'h5A, 1, 1, "inc wrap");
    check("inc wrap zero_a", int'(zero_a), 1);
    do_op(1, 0, 0, 0, 1, 0, "after inc wrap");

    // DEC wrap then CLR back to back.
    do_op(0, 3, 3, 8'hEE, 3, 3, "clr reg3");
    do_op(0, 2, 3, 8'h77, 3, 2, "dec wrap");
    do_op(0, 3, 3, 8'h77, 3, 3, "clr after dec");
    do_op(0, 1, 3, 0, 3, 0, "inc no wrap");
    do_op(0, 2, 3, 0, 3, 0, "dec no wrap");

    // Hold with toggling w_bus.
    for (int i = 0; i < 10; i++)
      do_op(1, $urandom_range(0, 3), $urandom_range(0, D - 1), $urandom_range(0, MASK),
            $urandom_range(0, D - 1), $urandom_range(0, D - 1), "hold");
    check_all_regs("after hold");

    // Same-cycle read of a LOAD target (forwarded only with the bypass macro).
    do_op(0, 0, 0, 8'h3C, 0, 0, "bypass load");
    do_op(0, 1, 0, 8'h99, 0, 0, "inc not forwarded");

    // Randomized operations.
    for (int i = 0; i < 300; i++) begin
      int wa;
      int m;
      wa = $urandom_range(0, D - 1);
      m  = $urandom_range(0, 3);
      // Bias toward boundary values so wraps happen often.
      if ($urandom_range(0, 3) == 0 && m == 0) begin
        do_op(0, 0, wa, ($urandom_range(0, 1) != 0) ? MASK : 0, wa, $urandom_range(0, D - 1),
              "rand edge");
      end else begin
        do_op(bit'($urandom_range(0, 4) == 0), m, wa, $urandom_range(0, MASK),
              $urandom_range(0, D - 1), $urandom_range(0, D - 1), "rand");
      end
    end
    check_all_regs("after random");

    // Asynchronous reset right after a wrap, then reset held across an edge with an operation.
    do_op(0, 0, 1, 8'hFF, 1, 1, "prep wrap");
    do_op(0, 0, 0, 8'h42, 0, 0, "prep reg0");
    @(negedge clk);
    load_n = 1'b0;
    mode   = 2'b01;
    waddr  = AW'(1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    for (int i = 0; i < D; i++) mdl[i] = 0;
    #1;
    check("async rst ovf", int'(ovf), 0);
    raddr_a = AW'(0);
    #0.5;
    check("async rst reg0", int'(alu_a), 0);
    check("async rst zero_a", int'(zero_a), 1);
    @(negedge clk);
    mode  = 2'b00;
    waddr = AW'(0);
    w_bus = 8'h55;
    @(posedge clk);
    #1;
    check("op during reset reg0", int'(alu_a), 0);
    check("op during reset ovf", int'(ovf), 0);
    @(negedge clk);
    load_n = 1'b1;
    rst_n  = 1'b1;
    check_all_regs("after mid reset");
    do_op(0, 0, 0, 8'h55, 0, 1, "first op after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
